// File: rtl/pid_seq_pkg.sv
// Shared definitions for the PID loop sequencer: state codes and default timing.
package pid_seq_pkg;

    localparam int unsigned STATE_W             = 3;
    localparam int unsigned ITER_W              = 8;
    localparam int unsigned DEF_PERIOD_BITS     = 16;
    localparam int unsigned DEF_TIMEOUT         = 64;
    localparam int unsigned DEF_COMPUTE_CYC     = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_OUTPUT  = 3'd3
    } state_t;

endpackage

// File: rtl/pid_seq_period_timer.sv
// Loop-period down-counter. tick_c is high while the count is zero (and the
// loop is enabled); the counter reloads from period on the following edge.
// While enable is low the count is held at zero so the first tick lands in
// the same cycle enable rises.
//   clk, reset   : clock, async active-high reset
//   enable       : loop run enable
//   period       : loop period minus 1, sampled at each reload
//   tick_c       : combinational period tick
module pid_seq_period_timer #(
    parameter int unsigned PERIOD_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    output logic                   tick_c
);

    logic [PERIOD_BITS-1:0] cnt_q;

    assign tick_c = enable && (cnt_q == '0);

    // Down-count, reload at zero, hold at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!enable) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= period;
        end else begin
            cnt_q <= cnt_q - PERIOD_BITS'(1);
        end
    end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Sequences one PID iteration per loop period: SPI-in sample, PID compute
// strobe, SPI-out stimulus. Reports phase timeouts (fault) and periods that
// arrive while an iteration is still running (overrun).
//   clk, reset            : clock, async active-high reset
//   enable                : loop run enable; low aborts to IDLE
//   period                : loop period in clk cycles minus 1
//   clr_flags             : sync clear of fault/overrun (set wins)
//   in_done / out_done    : SPI transfer-complete pulses
//   in_start / pid_stb / out_start : registered one-cycle phase pulses
//   busy, state           : FSM status
//   fault, overrun        : sticky flags
//   iter_cnt              : completed iterations, wrapping
module pid_loop_sequencer
    import pid_seq_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = DEF_PERIOD_BITS,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned COMPUTE_CYC = DEF_COMPUTE_CYC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   clr_flags,
    input  logic                   in_done,
    input  logic                   out_done,
    output logic                   in_start,
    output logic                   pid_stb,
    output logic                   out_start,
    output logic                   busy,
    output logic [2:0]             state,
    output logic                   fault,
    output logic                   overrun,
    output logic [7:0]             iter_cnt
);

    localparam int unsigned PH_W = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            tick_c;
    logic            in_start_d, pid_stb_d, out_start_d;
    logic            fault_set, overrun_set, iter_inc;

    pid_seq_period_timer #(
        .PERIOD_BITS (PERIOD_BITS)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .period (period),
        .tick_c (tick_c)
    );

    assign state       = state_q;
    assign busy        = (state_q != ST_IDLE);
    // Ticks are never queued: one landing mid-iteration is only reported
    assign overrun_set = tick_c && (state_q != ST_IDLE);

    // State and phase-counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next state, phase counter and pulse requests for the next cycle
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + PH_W'(1);
        in_start_d  = 1'b0;
        pid_stb_d   = 1'b0;
        out_start_d = 1'b0;
        fault_set   = 1'b0;
        iter_inc    = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d = '0;
                    if (tick_c) begin
                        state_d    = ST_SAMPLE;
                        in_start_d = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    // A done pulse alongside in_start belongs to no transfer of ours
                    if (in_done && !in_start) begin
                        state_d   = ST_COMPUTE;
                        pid_stb_d = 1'b1;
                        phase_d   = '0;
                    end else if (phase_q == PH_W'(TIMEOUT - 1)) begin
                        state_d   = ST_IDLE;
                        fault_set = 1'b1;
                        phase_d   = '0;
                    end
                end
                ST_COMPUTE: begin
                    if (phase_q == PH_W'(COMPUTE_CYC - 1)) begin
                        state_d     = ST_OUTPUT;
                        out_start_d = 1'b1;
                        phase_d     = '0;
                    end
                end
                ST_OUTPUT: begin
                    if (out_done) begin
                        state_d  = ST_IDLE;
                        iter_inc = 1'b1;
                        phase_d  = '0;
                    end else if (phase_q == PH_W'(TIMEOUT - 1)) begin
                        state_d   = ST_IDLE;
                        fault_set = 1'b1;
                        phase_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Registered pulses, sticky flags and iteration count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_start  <= 1'b0;
            pid_stb   <= 1'b0;
            out_start <= 1'b0;
            fault     <= 1'b0;
            overrun   <= 1'b0;
            iter_cnt  <= '0;
        end else begin
            in_start  <= in_start_d;
            pid_stb   <= pid_stb_d;
            out_start <= out_start_d;
            if (fault_set) begin
                fault <= 1'b1;
            end else if (clr_flags) begin
                fault <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (iter_inc) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Bench for pid_loop_sequencer: an auto-responder returns in_done/out_done at
// programmed delays, and a scoreboard queue of expected (pulse, cycle) pairs
// is checked by a negedge monitor as pulses appear.
module tb_pid_loop_sequencer;

    localparam int CC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] period = '0;
    logic        clr_flags = 1'b0;
    logic        in_done = 1'b0;
    logic        out_done = 1'b0;
    logic        in_start, pid_stb, out_start, busy, fault, overrun;
    logic [2:0]  state;
    logic [7:0]  iter_cnt;

    pid_loop_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .period    (period),
        .clr_flags (clr_flags),
        .in_done   (in_done),
        .out_done  (out_done),
        .in_start  (in_start),
        .pid_stb   (pid_stb),
        .out_start (out_start),
        .busy      (busy),
        .state     (state),
        .fault     (fault),
        .overrun   (overrun),
        .iter_cnt  (iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 in_start, 1 pid_stb, 2 out_start
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   in_dly = 0;
    int   out_dly = 0;
    int   in_due = -1;
    int   out_due = -1;

    task automatic push_exp(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Advance to 2 time units after the edge that starts cycle c
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Cycle counter and done-pulse responder
    task automatic drive_loop();
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            in_done  = (cyc == in_due);
            out_done = (cyc == out_due);
        end
    endtask

    // Scoreboard: every observed pulse must match a pending expectation
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (reset) begin
                in_due  = -1;
                out_due = -1;
            end else begin
                logic [2:0] p;
                p = {out_start, pid_stb, in_start};
                for (int k = 0; k < 3; k++) begin
                    if (p[k]) begin
                        int idx;
                        idx = -1;
                        for (int i = 0; i < exp_q.size(); i++)
                            if (idx < 0 && exp_q[i].kind == k) idx = i;
                        tests++;
                        if (idx < 0) begin
                            fails++;
                            $display("FAIL pulse_%0d: seen at cycle %0d, expected none", k, cyc);
                        end else begin
                            if (exp_q[idx].cyc !== cyc) begin
                                fails++;
                                $display("FAIL pulse_%0d: seen at cycle %0d, expected cycle %0d",
                                         k, cyc, exp_q[idx].cyc);
                            end
                            exp_q.delete(idx);
                        end
                        if (k == 0 && in_dly > 0) begin
                            in_due = cyc + in_dly;
                            push_exp(1, cyc + in_dly + 1);
                            push_exp(2, cyc + in_dly + 1 + CC);
                        end
                        if (k == 2 && out_dly > 0) out_due = cyc + out_dly;
                    end
                end
            end
        end
    endtask

    task automatic watchdog();
        forever begin
            @(posedge clk);
            if (cyc > 60000) begin
                $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
                $fatal(1, "bench timeout");
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        clr_flags = 1'b0;
        in_dly    = 0;
        out_dly   = 0;
        period    = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b1;
        #1;
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL rst_async_state: got %0d expected 0", state); end
        tests++; if ({busy, fault, overrun} !== 3'b000) begin fails++; $display("FAIL rst_async_flags: got %b expected 000", {busy, fault, overrun}); end
        tests++; if ({in_start, pid_stb, out_start} !== 3'b000) begin fails++; $display("FAIL rst_async_pulses: got %b expected 000", {in_start, pid_stb, out_start}); end
        tests++; if (iter_cnt !== 8'd0) begin fails++; $display("FAIL rst_async_iter: got %0d expected 0", iter_cnt); end
        do_reset();
        goto(cyc + 5);
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL rst_idle_state: got %0d expected 0", state); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    endtask

    // period=9; done delays chosen so each iteration finishes within the period
    task automatic test_periodic();
        int e;
        do_reset();
        period = 16'd9; in_dly = 3; out_dly = 2;
        e = cyc; enable = 1'b1;
        push_exp(0, e + 1); push_exp(0, e + 11); push_exp(0, e + 21);
        goto(e + 10);
        tests++; if (iter_cnt !== 8'd1) begin fails++; $display("FAIL per_iter1: got %0d expected 1", iter_cnt); end
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL per_idle: got %0d expected 0", state); end
        goto(e + 30);
        tests++; if (iter_cnt !== 8'd3) begin fails++; $display("FAIL per_iter3: got %0d expected 3", iter_cnt); end
        tests++; if ({fault, overrun} !== 2'b00) begin fails++; $display("FAIL per_flags: got %b expected 00", {fault, overrun}); end
        enable = 1'b0;
        goto(e + 33);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL per_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int e;
        do_reset();
        period = 16'd9; in_dly = 0; out_dly = 2;
        e = cyc; enable = 1'b1;
        push_exp(0, e + 1);
        goto(e + 64);
        tests++; if (state !== 3'd1) begin fails++; $display("FAIL to_last_sample: got %0d expected 1", state); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL to_early_fault: got %b expected 0", fault); end
        goto(e + 65);
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL to_state: got %0d expected 0", state); end
        tests++; if (fault !== 1'b1) begin fails++; $display("FAIL to_fault: got %b expected 1", fault); end
        tests++; if (iter_cnt !== 8'd0) begin fails++; $display("FAIL to_iter: got %0d expected 0", iter_cnt); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL to_overrun: got %b expected 1", overrun); end
        enable = 1'b0; clr_flags = 1'b1;
        goto(e + 66);
        clr_flags = 1'b0;
        tests++; if ({fault, overrun} !== 2'b00) begin fails++; $display("FAIL to_clear: got %b expected 00", {fault, overrun}); end
        // in_done in the 64th SAMPLE cycle must still be accepted
        period = 16'd200; in_dly = 63; out_dly = 1;
        e = cyc; enable = 1'b1;
        push_exp(0, e + 1);
        goto(e + 69);
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL to_edge_fault: got %b expected 0", fault); end
        tests++; if (iter_cnt !== 8'd1) begin fails++; $display("FAIL to_edge_iter: got %0d expected 1", iter_cnt); end
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL to_edge_state: got %0d expected 0", state); end
        enable = 1'b0;
        goto(e + 71);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL to_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        int e;
        do_reset();
        period = 16'd3; in_dly = 1; out_dly = 20;
        e = cyc; enable = 1'b1;
        push_exp(0, e + 1); push_exp(0, e + 29);
        goto(e + 4);
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ov_before: got %b expected 0", overrun); end
        goto(e + 5);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ov_set: got %b expected 1", overrun); end
        goto(e + 26);
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL ov_idle: got %0d expected 0", state); end
        tests++; if (iter_cnt !== 8'd1) begin fails++; $display("FAIL ov_iter: got %0d expected 1", iter_cnt); end
        goto(e + 27);
        clr_flags = 1'b1;
        goto(e + 28);
        clr_flags = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ov_clear: got %b expected 0", overrun); end
        goto(e + 29);
        enable = 1'b0; in_dly = 0;
        goto(e + 31);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL ov_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int e;
        do_reset();
        period = 16'd9; in_dly = 2; out_dly = 0;
        e = cyc; enable = 1'b1;
        push_exp(0, e + 1);
        goto(e + 7);
        tests++; if (state !== 3'd3) begin fails++; $display("FAIL ab_in_output: got %0d expected 3", state); end
        enable = 1'b0;
        goto(e + 8);
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL ab_state: got %0d expected 0", state); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_busy: got %b expected 0", busy); end
        goto(e + 80);
        tests++; if (iter_cnt !== 8'd0) begin fails++; $display("FAIL ab_iter: got %0d expected 0", iter_cnt); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL ab_fault: got %b expected 0", fault); end
        in_dly = 0;
        e = cyc; enable = 1'b1;
        push_exp(0, e + 1);
        goto(e + 1);
        enable = 1'b0;
        goto(e + 3);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL ab_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        int e;
        do_reset();
        period = 16'd9; in_dly = 2; out_dly = 2;
        e = cyc; enable = 1'b1;
        push_exp(0, e + 1);
        goto(e + 4);
        tests++; if (state !== 3'd2) begin fails++; $display("FAIL ar_compute: got %0d expected 2", state); end
        tests++; if (pid_stb !== 1'b1) begin fails++; $display("FAIL ar_stb: got %b expected 1", pid_stb); end
        in_dly = 0; out_dly = 0;
        reset = 1'b1;
        #1;
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL ar_state: got %0d expected 0", state); end
        tests++; if ({in_start, pid_stb, out_start, busy} !== 4'b0000) begin fails++; $display("FAIL ar_outs: got %b expected 0000", {in_start, pid_stb, out_start, busy}); end
        tests++; if (iter_cnt !== 8'd0) begin fails++; $display("FAIL ar_iter: got %0d expected 0", iter_cnt); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        period = 16'd0; in_dly = 1; out_dly = 1;
        e = cyc; enable = 1'b1;
        // 7-cycle iteration: IDLE, SAMPLE x2, COMPUTE x2, OUTPUT x2
        for (int k = 0; k < 256; k++) push_exp(0, e + 1 + 7 * k);
        goto(e + 7 * 255);
        tests++; if (iter_cnt !== 8'd255) begin fails++; $display("FAIL b2b_iter255: got %0d expected 255", iter_cnt); end
        goto(e + 7 * 256);
        tests++; if (iter_cnt !== 8'd0) begin fails++; $display("FAIL b2b_wrap: got %0d expected 0", iter_cnt); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL b2b_fault: got %b expected 0", fault); end
        enable = 1'b0;
        goto(e + 7 * 256 + 2);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        fork
            drive_loop();
            monitor_loop();
            watchdog();
        join_none
        test_reset();
        test_periodic();
        test_timeout();
        test_overrun();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
